// File: rtl/learning_coach_pkg.sv
// Shared constants, types and helpers for the learning-mode engine.
// No logic of its own; latency and backpressure are properties of the importing modules.
package learning_coach_pkg;

  localparam logic [2:0] LEARN_MODE = 3'b111;
  localparam logic [2:0] NOTE_END   = 3'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CHECK,
    ST_PROMPT,
    ST_HIT,
    ST_MISS,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [1:0] pitch;
    logic [2:0] note;
  } note_t;

  // Note 1..7 maps to key 0..6; the end marker lights nothing.
  function automatic logic [6:0] note_onehot(input logic [2:0] note);
    note_onehot = 7'd0;
    if (note != NOTE_END) note_onehot[note - 3'd1] = 1'b1;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [31:0] base_half(input int unsigned clk_hz, input int unsigned hz);
    return 32'(clk_hz / (2 * hz));
  endfunction

endpackage

// File: rtl/learning_coach_rom.sv
// Song ROM: {pitch, note} per step, four songs, note 0 terminates a song.
// One-cycle synchronous read latency, free-running (no handshake).
module learn_song_rom
  import learning_coach_pkg::*;
#(
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic [1:0]       song_i,
  input  logic [IDX_W-1:0] idx_i,
  output note_t            word_o
);

  note_t       word_d;
  int unsigned a;

  always_comb begin
    a      = 32'(idx_i);
    word_d = {2'd0, NOTE_END};
    case (song_i)
      2'd0: begin
        case (a)
          0:       word_d = {2'd0, 3'd1};
          1:       word_d = {2'd0, 3'd2};
          2:       word_d = {2'd0, 3'd3};
          default: word_d = {2'd0, NOTE_END};
        endcase
      end
      2'd1: begin
        case (a)
          0:       word_d = {2'd1, 3'd5};
          1:       word_d = {2'd1, 3'd3};
          default: word_d = {2'd0, NOTE_END};
        endcase
      end
      2'd2: begin
        case (a)
          0:       word_d = {2'd0, 3'd1};
          1:       word_d = {2'd0, 3'd2};
          2:       word_d = {2'd0, 3'd3};
          3:       word_d = {2'd0, 3'd4};
          default: word_d = {2'd0, NOTE_END};
        endcase
      end
      // Song 3 has no end marker: it runs the full index range.
      default: word_d = {2'd0, 3'd1};
    endcase
  end

  always_ff @(posedge clk) begin
    word_o <= word_d;
  end

endmodule

// File: rtl/learning_coach.sv
// Learning-mode engine: prompts each song note on the LEDs, debounces keys, scores presses.
// Press reaches the FSM ~DEBOUNCE+3 cycles after a raw edge; no backpressure, presses outside PROMPT are dropped.
module learning_coach
  import learning_coach_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned TIMEOUT_MS  = 3000,
  parameter int unsigned FLASH_MS    = 250,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned SONG_LEN    = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] mode,
  input  logic [1:0] song_num,
  input  logic       pause,
  input  logic [6:0] key,
  input  logic [1:0] pitch,
  output logic [7:0] led,
  output logic       speaker,
  output logic [7:0] score,
  output logic [7:0] misses,
  output logic       done
);

  localparam int unsigned CYC_MS  = CLK_HZ / 1000;
  localparam int unsigned DB_CYC  = DEBOUNCE_MS * CYC_MS;
  localparam int unsigned TMO_CYC = TIMEOUT_MS * CYC_MS;
  localparam int unsigned FL_CYC  = FLASH_MS * CYC_MS;
  localparam int IDX_W = $clog2(SONG_LEN);
  localparam int DB_W  = $clog2(DB_CYC + 1);
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  localparam int FL_W  = $clog2(FL_CYC + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  // One extra index bit so that idx==SONG_LEN is representable and caught in CHECK.
  localparam logic [IDX_W:0] IDX_END = (IDX_W + 1)'(SONG_LEN);
  localparam logic [31:0] HALF_TBL [8] = '{
    base_half(CLK_HZ, 262), base_half(CLK_HZ, 294), base_half(CLK_HZ, 330),
    base_half(CLK_HZ, 349), base_half(CLK_HZ, 392), base_half(CLK_HZ, 440),
    base_half(CLK_HZ, 494), base_half(CLK_HZ, 494)};

  logic learn;
  assign learn = (mode == LEARN_MODE);

  logic [6:0]      sync1_q, sync2_q, kdb_q, kdb_prev_q, press;
  logic [DB_W-1:0] db_cnt_q [7];

  always_ff @(posedge clk) begin
    if (rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      kdb_q      <= '0;
      kdb_prev_q <= '0;
      for (int i = 0; i < 7; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= key;
      sync2_q    <= sync1_q;
      kdb_prev_q <= kdb_q;
      for (int i = 0; i < 7; i++) begin
        if (sync2_q[i] == kdb_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_W'(DB_CYC - 1)) begin
          kdb_q[i]    <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  assign press = kdb_q & ~kdb_prev_q;

  state_e           state_q, state_d;
  logic [IDX_W:0]   idx_q, idx_d;
  logic [1:0]       song_q, song_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [FL_W-1:0]  fl_q, fl_d;
  logic [7:0]       score_q, score_d, miss_q, miss_d;
  logic             miss_ev;
  note_t            rom_word;
  logic [6:0]       exp_oh;

  learn_song_rom #(.IDX_W(IDX_W)) u_rom (
    .clk    (clk),
    .song_i (song_q),
    .idx_i  (idx_q[IDX_W-1:0]),
    .word_o (rom_word)
  );

  assign exp_oh = note_onehot(rom_word.note);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    song_d  = song_q;
    tries_d = tries_q;
    tmo_d   = tmo_q;
    fl_d    = fl_q;
    score_d = score_q;
    miss_d  = miss_q;
    miss_ev = 1'b0;
    led     = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (learn) begin
          state_d = ST_FETCH;
          idx_d   = '0;
          score_d = '0;
          miss_d  = '0;
          tries_d = '0;
          song_d  = song_num;
        end
      end
      ST_FETCH: state_d = ST_CHECK;
      ST_CHECK: begin
        if (idx_q == IDX_END || rom_word.note == NOTE_END) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_PROMPT;
          tmo_d   = '0;
        end
      end
      ST_PROMPT: begin
        led  = {1'b0, exp_oh};
        fl_d = '0;
        if (!pause) begin
          // A press decides the note even if the timeout expires on the same cycle.
          if (press != 7'd0) begin
            if (press == exp_oh && pitch == rom_word.pitch) begin
              state_d = ST_HIT;
              score_d = sat_inc(score_q);
              tries_d = '0;
            end else begin
              miss_ev = 1'b1;
            end
          end else if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
            miss_ev = 1'b1;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        if (miss_ev) begin
          state_d = ST_MISS;
          miss_d  = sat_inc(miss_q);
          tries_d = tries_q + TRY_W'(1);
        end
      end
      ST_HIT: begin
        led = 8'h7F;
        if (!pause) begin
          if (fl_q == FL_W'(FL_CYC - 1)) begin
            state_d = ST_FETCH;
            idx_d   = idx_q + (IDX_W + 1)'(1);
          end else begin
            fl_d = fl_q + FL_W'(1);
          end
        end
      end
      ST_MISS: begin
        led = {1'b1, exp_oh};
        if (!pause) begin
          if (fl_q != FL_W'(FL_CYC - 1)) begin
            fl_d = fl_q + FL_W'(1);
          end else if (tries_q == TRY_W'(MAX_TRIES)) begin
            state_d = ST_FETCH;
            tries_d = '0;
            idx_d   = idx_q + (IDX_W + 1)'(1);
          end else begin
            state_d = ST_PROMPT;
            tmo_d   = '0;
          end
        end
      end
      ST_DONE: led = 8'hAA;
      default: state_d = ST_IDLE;
    endcase
    if (!learn) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      song_q  <= '0;
      tries_q <= '0;
      tmo_q   <= '0;
      fl_q    <= '0;
      score_q <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      song_q  <= song_d;
      tries_q <= tries_d;
      tmo_q   <= tmo_d;
      fl_q    <= fl_d;
      score_q <= score_d;
      miss_q  <= miss_d;
    end
  end

  assign score  = score_q;
  assign misses = miss_q;
  assign done   = (state_q == ST_DONE);

  // Tone follows the lowest held key; a higher octave halves the period per step.
  logic [2:0]  low_k;
  logic [31:0] half_sel, tone_cnt_q, tone_cnt_d;
  logic        spk_q, spk_d;

  always_comb begin
    low_k = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (kdb_q[i]) low_k = 3'(i);
    end
    half_sel = HALF_TBL[low_k] >> pitch;
    if (half_sel == 32'd0) half_sel = 32'd1;
    tone_cnt_d = tone_cnt_q + 32'd1;
    spk_d      = spk_q;
    if (!learn || pause || kdb_q == 7'd0 || kdb_q != kdb_prev_q) begin
      tone_cnt_d = '0;
      spk_d      = 1'b0;
    end else if (tone_cnt_q >= half_sel - 32'd1) begin
      tone_cnt_d = '0;
      spk_d      = ~spk_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      tone_cnt_q <= '0;
      spk_q      <= 1'b0;
    end else begin
      tone_cnt_q <= tone_cnt_d;
      spk_q      <= spk_d;
    end
  end

  assign speaker = spk_q;

endmodule

// File: tb/tb_learning_coach.sv
// Directed bench for learning_coach at 1 kHz sim clock (1 cycle = 1 ms).
// Drives and samples on the falling edge; expected values are hand-computed.
module tb_learning_coach;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] mode;
  logic [1:0] song_num;
  logic       pause;
  logic [6:0] key;
  logic [1:0] pitch;
  logic [7:0] led, score, misses;
  logic       speaker, done;

  int n_chk  = 0;
  int n_pass = 0;
  int cnt;
  int toggles;
  logic prev_spk;

  always #5 clk = ~clk;

  learning_coach #(
    .CLK_HZ(1000), .DEBOUNCE_MS(2), .TIMEOUT_MS(50), .FLASH_MS(5),
    .MAX_TRIES(3), .SONG_LEN(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .song_num(song_num), .pause(pause),
    .key(key), .pitch(pitch), .led(led), .speaker(speaker), .score(score),
    .misses(misses), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_led(input logic [7:0] v, input int budget, input string tag);
    int k = 0;
    while (led !== v && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, {24'd0, led}, {24'd0, v});
  endtask

  task automatic hold_count(input logic [7:0] v, output int n);
    n = 0;
    while (led === v && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic play_hit(input logic [6:0] k, input logic [7:0] prompt, input string tag);
    wait_led(prompt, 30, {tag, "_prompt"});
    key = k;
    wait_led(8'h7F, 20, {tag, "_hit"});
    key = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; mode = 3'b000; song_num = 2'd0; pause = 1'b0; key = '0; pitch = 2'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_led", led, 0);
    check("rst_score", score, 0);
    check("rst_misses", misses, 0);
    check("rst_done", done, 0);
    check("rst_speaker", speaker, 0);

    // Clean run through song 0: C, D, E.
    song_num = 2'd0; mode = 3'b111;
    play_hit(7'h01, 8'h01, "s0_c");
    check("s0_score1", score, 1);
    play_hit(7'h02, 8'h02, "s0_d");
    play_hit(7'h04, 8'h04, "s0_e");
    wait_led(8'hAA, 20, "s0_done_led");
    check("s0_score", score, 3);
    check("s0_misses", misses, 0);
    check("s0_done", done, 1);

    mode = 3'b001;
    @(negedge clk);
    check("leave_led", led, 0);
    check("leave_done", done, 0);
    check("leave_score_held", score, 3);

    // Wrong key on C: miss flash 0x81 for exactly 5 cycles, then re-prompt.
    mode = 3'b111;
    wait_led(8'h01, 20, "t3_prompt");
    check("t3_score_clr", score, 0);
    key = 7'h02;
    wait_led(8'h81, 20, "t3_miss_led");
    hold_count(8'h81, cnt);
    check("t3_flash_len", cnt, 5);
    check("t3_misses", misses, 1);
    check("t3_reprompt", led, 8'h01);
    key = '0;

    // Three timeouts on C, then D is prompted.
    mode = 3'b001;
    @(negedge clk);
    mode = 3'b111;
    wait_led(8'h01, 20, "t4_prompt");
    hold_count(8'h01, cnt);
    check("t4_tmo_len", cnt, 50);
    wait_led(8'h02, 300, "t4_next_note");
    check("t4_misses", misses, 3);
    check("t4_score", score, 0);

    // Single-cycle glitches on key[0] must not register.
    for (int i = 0; i < 6; i++) begin
      key = 7'h01; @(negedge clk);
      key = 7'h00; @(negedge clk);
    end
    repeat (6) @(negedge clk);
    check("t5_glitch_misses", misses, 3);
    check("t5_glitch_led", led, 8'h02);
    key = 7'h01;
    toggles = 0;
    prev_spk = speaker;
    repeat (25) begin
      @(negedge clk);
      if (speaker !== prev_spk) toggles++;
      prev_spk = speaker;
    end
    check("t5_one_press", misses, 4);
    check("t5_led_back", led, 8'h02);
    check("t5_speaker_toggles", toggles >= 10, 1);
    pause = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_speaker_pause", speaker, 0);
    pause = 1'b0;
    key = '0;
    play_hit(7'h02, 8'h02, "t5_d");
    play_hit(7'h04, 8'h04, "t5_e");
    wait_led(8'hAA, 20, "t5_done_led");
    check("t5_score", score, 2);
    check("t5_misses_end", misses, 4);

    // Song 1 wants pitch 1: correct key at pitch 0 is a miss.
    mode = 3'b001;
    @(negedge clk);
    song_num = 2'd1; pitch = 2'd0; mode = 3'b111;
    wait_led(8'h10, 20, "t7_prompt");
    key = 7'h10;
    wait_led(8'h90, 20, "t7_pitch_miss");
    check("t7_misses", misses, 1);
    key = '0;
    pitch = 2'd1;
    play_hit(7'h10, 8'h10, "t7_g");
    check("t7_score", score, 1);

    // Pause for 100 cycles in PROMPT: no timeout, presses ignored.
    wait_led(8'h04, 20, "t6_prompt");
    pause = 1'b1;
    key = 7'h04;
    repeat (10) @(negedge clk);
    key = '0;
    repeat (90) @(negedge clk);
    check("t6_pause_led", led, 8'h04);
    check("t6_pause_misses", misses, 1);
    check("t6_pause_score", score, 1);
    pause = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_unpause_led", led, 8'h04);
    mode = 3'b001;
    @(negedge clk);
    check("t6_mode_led", led, 0);
    check("t6_mode_score", score, 1);
    check("t6_mode_done", done, 0);
    check("t6_mode_speaker", speaker, 0);

    // Reset mid-PROMPT with score 3.
    song_num = 2'd2; pitch = 2'd0; mode = 3'b111;
    play_hit(7'h01, 8'h01, "t1_c");
    play_hit(7'h02, 8'h02, "t1_d");
    play_hit(7'h04, 8'h04, "t1_e");
    wait_led(8'h08, 20, "t1_prompt_f");
    check("t1_score_pre", score, 3);
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_led", led, 0);
    check("t1_score", score, 0);
    check("t1_misses", misses, 0);
    check("t1_done", done, 0);
    check("t1_speaker", speaker, 0);
    rst_n = 1'b0; mode = 3'b000; song_num = 2'd3;
    @(negedge clk);

    // Song 3 has no end marker: done only after SONG_LEN notes.
    mode = 3'b111;
    for (int i = 0; i < 32; i++) play_hit(7'h01, 8'h01, "t8_c");
    wait_led(8'hAA, 20, "t8_done_led");
    check("t8_score", score, 32);
    check("t8_done", done, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
